// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: write-stream fill and read-burst streaming for a 256x32 RAM.
// Write stream s_* -> ram_*; read burst rd_* -> m_* through a 2-entry buffer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_valid/s_ready/s_data write stream (IDLE only)
//   rd_start/rd_base/rd_len read burst request (IDLE only, len 1..256)
//   m_valid/m_ready/m_data/m_last read stream
//   busy, done, wr_ptr    status
//   ram_we/ram_addr/ram_din/ram_dout RAM port (1-cycle read latency)
module ram_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;

  logic       w_req;
  logic       w_start;
  logic       w_s_ready;
  logic       w_wr;
  logic       w_pop;
  logic       w_issue;
  logic [2:0] w_occ;

  assign w_req = rd_start && (rd_len != '0);
  assign w_start = w_req && (r_state == S_IDLE);

  // Gated by rst_n so s_ready is low while reset is held.
  assign w_s_ready = rst_n && (r_state == S_IDLE) && !w_req;
  assign w_wr = s_valid && w_s_ready;
  assign w_pop = (r_count != 2'd0) && m_ready;

  // Credit counts this cycle's pop so a full-rate stream never bubbles.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight}
               - {2'b00, w_pop};
  assign w_issue = (r_state == S_RD) && (r_issue_cnt != '0)
                && (w_occ < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RD;
      S_RD:    if (w_issue && r_issue_cnt == CNT_W'(1))
                 w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && r_beat_cnt == CNT_W'(1))
                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = w_s_ready;
    m_valid  = (r_count != 2'd0);
    m_data   = r_buf[r_head];
    m_last   = m_valid && (r_beat_cnt == CNT_W'(1));
    done     = w_pop && (r_beat_cnt == CNT_W'(1));
    busy     = (r_state != S_IDLE);
    wr_ptr   = r_wr_ptr;
    ram_we   = w_wr;
    ram_addr = w_issue ? r_rd_ptr : r_wr_ptr;
    ram_din  = w_wr ? s_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_start) begin
        r_rd_ptr    <= rd_base;
        r_issue_cnt <= rd_len;
        r_beat_cnt  <= rd_len;
      end else begin
        if (w_issue) begin
          r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
          r_issue_cnt <= r_issue_cnt - CNT_W'(1);
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt - CNT_W'(1);
      end
      r_inflight <= w_issue;
      // Data for last cycle's issue is on ram_dout now.
      if (r_inflight) begin
        r_buf[r_tail] <= ram_dout;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench for ram_burst_ctrl with a RAM model.
// Expected data comes from a shadow copy of every word the bench writes.
module tb_ram_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        rd_start;
  logic [7:0]  rd_base;
  logic [8:0]  rd_len;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [7:0]  wr_ptr;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  bit          rp [8] = '{0, 0, 0, 1, 0, 1, 1, 1};

  int n_vec = 0;
  int n_err = 0;

  ram_burst_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done), .wr_ptr(wr_ptr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    int issued;
    int dones;
    bit prev_stall;
    logic [31:0] prev_data;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; m_ready = 1'b0;

    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    chk("rel_s_ready", s_ready, 1);

    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + i;
      #1;
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, i);
      chk("wr_din", ram_din, 32'hA0 + i);
      shadow[i] = 32'hA0 + i;
      step();
    end
    s_valid = 1'b0;
    #1;
    chk("wr_ptr4", wr_ptr, 4);
    chk("wr_idle_we", ram_we, 0);

    m_ready = 1'b1; rd_base = 8'd0; rd_len = 9'd4; rd_start = 1'b1;
    #1;
    chk("ns_coll_s_ready", s_ready, 0);
    chk("ns_busy_T", busy, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      rd_start = 1'b0;
      #1;
      chk("ns_busy", busy, (k <= 6));
      if (k <= 4) chk("ns_addr", ram_addr, k - 1);
      chk("ns_m_valid", m_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("ns_data", m_data, 32'hA0 + k - 3);
      chk("ns_last", m_last, (k == 6));
      chk("ns_done", done, (k == 6));
    end

    m_ready = 1'b0; rd_base = 8'd0; rd_len = 9'd4; rd_start = 1'b1;
    #1;
    beats = 0; issued = 0; dones = 0; prev_stall = 0; prev_data = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      rd_start = 1'b0;
      m_ready = (k <= 8) ? rp[k-1] : 1'b1;
      #1;
      if (busy && issued < 4 && ram_addr == 8'(issued)) issued++;
      if (prev_stall) begin
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("bp_data", m_data, shadow[beats]);
        chk("bp_last", m_last, (beats == 3));
        beats++;
      end
      chk("bp_outstanding", (issued - beats <= 2), 1);
      if (done) dones++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (!busy && k > 2) break;
    end
    chk("bp_beats", beats, 4);
    chk("bp_issued", issued, 4);
    chk("bp_dones", dones, 1);

    for (int a = 4; a < 254; a++) begin
      s_valid = 1'b1; s_data = a;
      shadow[a] = a;
      step();
    end
    chk("wrap_wr_ptr254", wr_ptr, 254);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] wa;
      wa = 8'(254 + i);
      s_valid = 1'b1; s_data = i + 1;
      #1;
      chk("wrap_wr_addr", ram_addr, wa);
      shadow[wa] = i + 1;
      step();
    end
    s_valid = 1'b0;
    #1;
    chk("wrap_wr_ptr2", wr_ptr, 2);

    m_ready = 1'b1; rd_base = 8'd254; rd_len = 9'd4; rd_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      logic [7:0] ea;
      step();
      rd_start = 1'b0;
      #1;
      ea = 8'(254 + k - 1);
      if (k <= 4) chk("wrap_addr", ram_addr, ea);
      if (k >= 3 && k <= 6) chk("wrap_data", m_data, k - 2);
      chk("wrap_last", m_last, (k == 6));
    end

    rd_base = 8'd0; rd_len = 9'd256; rd_start = 1'b1;
    beats = 0; dones = 0;
    for (int k = 1; k <= 2000; k++) begin
      step();
      rd_start = 1'b0;
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_valid && m_ready) begin
        if (m_data !== shadow[8'(beats)] || m_last !== (beats == 255))
          chk("full_beat", {m_last, m_data[30:0]},
              {(beats == 255), shadow[8'(beats)][30:0]});
        beats++;
      end
      if (done) dones++;
      if (!busy && k > 2) break;
    end
    chk("full_beats", beats, 256);
    chk("full_dones", dones, 1);

    s_valid = 1'b1; s_data = 32'h55;
    rd_start = 1'b1; rd_base = 8'd0; rd_len = 9'd2; m_ready = 1'b1;
    #1;
    chk("col_s_ready", s_ready, 0);
    chk("col_we", ram_we, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      rd_start = (k == 2);
      rd_len = (k == 2) ? 9'd3 : 9'd2;
      #1;
      if (k <= 4) begin
        chk("col_rd_s_ready", s_ready, 0);
        chk("col_busy", busy, 1);
      end
      if (k == 3) chk("col_d0", m_data, shadow[0]);
      if (k == 4) chk("col_d1", m_data, shadow[1]);
      chk("col_done", done, (k == 4));
      if (k == 5) begin
        chk("col_after_s_ready", s_ready, 1);
        chk("col_after_we", ram_we, 1);
        chk("col_after_addr", ram_addr, 2);
        chk("col_after_din", ram_din, 32'h55);
        chk("col_after_busy", busy, 0);
      end
    end
    step();
    s_valid = 1'b0;
    shadow[2] = 32'h55;
    #1;
    chk("col_wr_ptr", wr_ptr, 3);

    rd_start = 1'b1; rd_len = 9'd0;
    #1;
    chk("len0_s_ready", s_ready, 1);
    step();
    rd_start = 1'b0;
    #1;
    chk("len0_busy", busy, 0);
    chk("len0_m_valid", m_valid, 0);

    m_ready = 1'b0; rd_base = 8'd0; rd_len = 9'd4; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    step();
    chk("mrst_pre_valid", m_valid, 1);
    chk("mrst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_we", ram_we, 0);
    chk("mrst_wr_ptr", wr_ptr, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_m_data", m_data, 0);
    chk("mrst_m_last", m_last, 0);
    chk("mrst_addr", ram_addr, 0);
    #10;
    rst_n = 1'b1;
    step();
    chk("mrst_rel_s_ready", s_ready, 1);
    chk("mrst_rel_busy", busy, 0);
    chk("mrst_rel_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
